// File: rtl/zbus_port_dec.sv
// Z80 I/O cycle decoder for the AY/YM ports #FFFD and #BFFD: synchronises the
// async Z80 bus, filters strobe glitches and emits one write strobe per cycle.
module zbus_port_dec #(
  parameter int FILT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iorq_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       m1_n,
  input  logic       a15,
  input  logic       a14,
  input  logic       a1,
  input  logic [7:0] zd,
  output logic [7:0] d,
  output logic       cfg_wrstb,
  output logic       reg_wrstb,
  output logic       dat_wrstb,
  output logic       rd_fffd,
  output logic       rd_bffd
);

  localparam int SW = 15;
  localparam logic [SW-1:0] SYNC_RST = {4'b1111, 3'b000, 8'h00};
  localparam logic [2:0] FILT_M1 = 3'(FILT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t          state;
  logic [2:0]      cnt;
  logic [1:0]      warm;
  logic [SW-1:0]   sync1;
  logic [SW-1:0]   sync2;

  logic       s_iorq_n, s_wr_n, s_rd_n, s_m1_n, s_a15, s_a14, s_a1;
  logic [7:0] s_zd;
  logic       active, is_wr, is_rd, hit_fffd, hit_bffd;

  // Data and address share the strobes' two flops so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
    end else begin
      sync1 <= {iorq_n, wr_n, rd_n, m1_n, a15, a14, a1, zd};
      sync2 <= sync1;
    end
  end

  assign {s_iorq_n, s_wr_n, s_rd_n, s_m1_n, s_a15, s_a14, s_a1, s_zd} = sync2;

  assign is_wr    = !s_wr_n && s_rd_n;
  assign is_rd    = s_wr_n && !s_rd_n;
  assign active   = !s_iorq_n && s_m1_n && (is_wr || is_rd);
  assign hit_fffd = s_a15 && s_a14 && !s_a1;
  assign hit_bffd = s_a15 && !s_a14 && !s_a1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HOLD;
      cnt       <= 3'd0;
      warm      <= 2'b00;
      d         <= 8'h00;
      cfg_wrstb <= 1'b0;
      reg_wrstb <= 1'b0;
      dat_wrstb <= 1'b0;
      rd_fffd   <= 1'b0;
      rd_bffd   <= 1'b0;
    end else begin
      warm      <= {warm[0], 1'b1};
      cfg_wrstb <= 1'b0;
      reg_wrstb <= 1'b0;
      dat_wrstb <= 1'b0;
      case (state)
        IDLE: begin
          if (active) begin
            if (cnt == FILT_M1) begin
              state <= DECODE;
              cnt   <= 3'd0;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end else begin
            cnt <= 3'd0;
          end
        end
        DECODE: begin
          state <= HOLD;
          cnt   <= 3'd0;
          if (is_wr && (hit_fffd || hit_bffd)) d <= s_zd;
          cfg_wrstb <= is_wr && hit_fffd && (s_zd[7:4] == 4'hF);
          reg_wrstb <= is_wr && hit_fffd && (s_zd[7:4] != 4'hF);
          dat_wrstb <= is_wr && hit_bffd;
          rd_fffd   <= is_rd && hit_fffd;
          rd_bffd   <= is_rd && hit_bffd;
        end
        HOLD: begin
          // The synchroniser resets to "iorq high"; those reset values must not
          // count as a real gap, or a cycle in flight at reset would re-arm.
          if (s_iorq_n && warm[1]) begin
            if (cnt == FILT_M1) begin
              state   <= IDLE;
              cnt     <= 3'd0;
              rd_fffd <= 1'b0;
              rd_bffd <= 1'b0;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end else begin
            cnt <= 3'd0;
          end
        end
        default: begin
          state <= HOLD;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

endmodule
